cpu_example_fetch: RTL and testbench

//  Instruction fetch unit for the example CPU. It is the initiator side of the program ROM read port.
//  It drives the ROM address from its program counter and samples the ROM word in the same cycle, because the ROM read is combinational.
//  It presents the sampled word to decode through a one-entry valid/ready register stage.
//  It accepts PC redirects (writes to R0, taken branches) and a halt request from execute.

---
 rtl/cpu_example_fetch_if.sv | 32 +++
 rtl/cpu_example_fetch.sv | 125 ++++++++++++
 tb/tb_cpu_example_fetch.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_example_fetch_if.sv
// rtl/cpu_example_fetch_if.sv - ROM read port and decode handshake bundle for the fetch unit
interface cpu_example_fetch_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic [ADDR_W-1:0]  rom_addr;
   logic [INSTR_W-1:0] rom_data;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_valid;
   logic               instr_ready;

   // fetch unit side: drives the ROM address and the decode register stage
   modport master (
      output rom_addr,
      input  rom_data,
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready
   );

   // ROM / decode side
   modport slave (
      input  rom_addr,
      output rom_data,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/cpu_example_fetch.sv
// rtl/cpu_example_fetch.sv - instruction fetch unit with one-entry valid/ready output stage
module cpu_example_fetch #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   cpu_example_fetch_if.master bus,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc,
   input  logic                halt_req,
   output logic                halted,
   output logic [15:0]         fetch_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [ADDR_W-1:0]  pc;
   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  instr_pc_q;
   logic               instr_valid_q;

   // decoded actions for this cycle; at most one of halt/redirect/fire is set
   logic               do_halt;
   logic               do_redirect;
   logic               fire;
   logic               consume;

   // the ROM is combinational, so the address is the pc itself
   assign bus.rom_addr    = pc;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign halted          = (state == HALT);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and per-cycle action select: halt beats redirect beats fire
   always_comb begin
      state_nxt   = state;
      do_halt     = 1'b0;
      do_redirect = 1'b0;
      fire        = 1'b0;
      // instr_valid is always 0 in HALT, so this never counts there
      consume     = instr_valid_q & bus.instr_ready;
      unique case (state)
         IDLE: begin
            if (halt_req) begin
               do_halt   = 1'b1;
               state_nxt = HALT;
            end else begin
               do_redirect = redirect;
               if (run) begin
                  state_nxt = FETCH;
               end
            end
         end
         FETCH: begin
            if (halt_req) begin
               do_halt   = 1'b1;
               state_nxt = HALT;
            end else if (redirect) begin
               do_redirect = 1'b1;
            end else begin
               fire = run & (~instr_valid_q | bus.instr_ready);
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // pc and output register stage
   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else if (do_halt) begin
         instr_valid_q <= 1'b0;
      end else if (do_redirect) begin
         // held word is dropped; the target is fetched on a later cycle
         pc            <= redirect_pc;
         instr_valid_q <= 1'b0;
      end else if (fire) begin
         instr_q       <= bus.rom_data;
         instr_pc_q    <= pc;
         instr_valid_q <= 1'b1;
         pc            <= pc + 1'b1;
      end else if (consume) begin
         instr_valid_q <= 1'b0;
      end
   end

   // saturating count of words accepted by decode
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= 16'd0;
      end else if (consume && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_cpu_example_fetch.sv
// tb/tb_cpu_example_fetch.sv - self-checking bench for cpu_example_fetch
module tb_cpu_example_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        halt_req;
   logic        halted;
   logic [15:0] fetch_count;

   logic [15:0] rom [256];

   int total = 0;
   int bad   = 0;

   // reference state: what decode should see, derived from the behavioural rules
   bit          m_started;
   bit          m_stopped;
   logic [7:0]  m_pc;
   bit          m_valid;
   logic [15:0] m_instr;
   logic [7:0]  m_ipc;
   int          m_count;

   cpu_example_fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

   assign bus.rom_data = rom[bus.rom_addr];

   cpu_example_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'd0)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .bus         (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt_req    (halt_req),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0;
      m_stopped = 0;
      m_pc      = 8'd0;
      m_valid   = 0;
      m_instr   = 16'd0;
      m_ipc     = 8'd0;
      m_count   = 0;
   endtask

   // one clock edge of the reference, using the inputs currently driven
   task automatic model_step();
      bit taken;
      taken = m_valid && bus.instr_ready;
      if (rst) begin
         model_reset();
      end else if (!m_stopped) begin
         if (taken && m_count < 65535) m_count++;
         if (halt_req) begin
            m_stopped = 1;
            m_valid   = 0;
         end else if (redirect) begin
            m_pc    = redirect_pc;
            m_valid = 0;
         end else if (m_started && run && (!m_valid || bus.instr_ready)) begin
            m_instr = rom[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 8'd1;
         end else if (taken) begin
            m_valid = 0;
         end
         if (!halt_req && run) m_started = 1;
      end
   endtask

   task automatic compare_model();
      check("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
      check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      check("instr", 32'(bus.instr), 32'(m_instr));
      check("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
      check("halted", 32'(halted), 32'(m_stopped));
      check("fetch_count", 32'(fetch_count), 32'(m_count));
   endtask

   // check at the falling edge, drive the next inputs, step the model at the rising edge
   task automatic cyc(input bit i_rst, input bit i_run, input bit i_rdy,
                      input bit i_redir, input logic [7:0] i_rpc, input bit i_halt);
      @(negedge clk);
      compare_model();
      rst             = i_rst;
      run             = i_run;
      bus.instr_ready = i_rdy;
      redirect        = i_redir;
      redirect_pc     = i_rpc;
      halt_req        = i_halt;
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      int saved;
      for (int a = 0; a < 256; a++) rom[a] = 16'hA000 | 16'(a);
      rst = 1; run = 0; bus.instr_ready = 0; redirect = 0; redirect_pc = 0; halt_req = 0;
      @(posedge clk);
      model_reset();
      #1;
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_addr", 32'(bus.rom_addr), 32'd0);

      // streaming from reset: first valid two cycles after run rises
      cyc(0, 1, 1, 0, 0, 0);
      check("lat_valid0", 32'(bus.instr_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 1, 1, 0, 0, 0);
         check("stream_valid", 32'(bus.instr_valid), 32'd1);
         check("stream_pc", 32'(bus.instr_pc), 32'(i));
         check("stream_instr", 32'(bus.instr), 32'(16'hA000 | 16'(i)));
      end
      check("stream_count", 32'(fetch_count), 32'd5);

      // stall holds word and address
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0, 0, 0);
         check("stall_instr", 32'(bus.instr), 32'h0000A005);
         check("stall_addr", 32'(bus.rom_addr), 32'd6);
      end
      cyc(0, 1, 1, 0, 0, 0);
      check("resume_pc6", 32'(bus.instr_pc), 32'd6);
      cyc(0, 1, 1, 0, 0, 0);
      check("resume_pc7", 32'(bus.instr_pc), 32'd7);

      // redirect while a word is held
      cyc(0, 1, 0, 1, 8'd4, 0);
      cyc(0, 1, 0, 0, 0, 0);
      check("held_pc4", 32'(bus.instr_pc), 32'd4);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 8'd11, 0);
      check("redir_valid0", 32'(bus.instr_valid), 32'd0);
      check("redir_addr", 32'(bus.rom_addr), 32'd11);
      cyc(0, 1, 1, 0, 0, 0);
      check("redir_valid", 32'(bus.instr_valid), 32'd1);
      check("redir_pc11", 32'(bus.instr_pc), 32'd11);

      // wrap from 255
      cyc(0, 1, 1, 1, 8'd255, 0);
      cyc(0, 1, 1, 0, 0, 0);
      check("wrap_255", 32'(bus.instr_pc), 32'd255);
      cyc(0, 1, 1, 0, 0, 0);
      check("wrap_0", 32'(bus.instr_pc), 32'd0);
      cyc(0, 1, 1, 0, 0, 0);
      check("wrap_1", 32'(bus.instr_pc), 32'd1);

      // halt beats redirect; the held word is still counted once
      saved = m_count;
      cyc(0, 1, 1, 1, 8'd50, 1);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_valid", 32'(bus.instr_valid), 32'd0);
      check("halt_addr", 32'(bus.rom_addr), 32'd2);
      check("halt_count", 32'(fetch_count), 32'(saved + 1));
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 1, 8'd9, 0);
         check("halt_frozen", 32'(bus.rom_addr), 32'd2);
         check("halt_stays", 32'(halted), 32'd1);
      end

      // reset during a stall
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      check("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
      cyc(1, 1, 0, 0, 0, 0);
      check("rst2_valid", 32'(bus.instr_valid), 32'd0);
      check("rst2_addr", 32'(bus.rom_addr), 32'd0);
      check("rst2_instr", 32'(bus.instr), 32'd0);
      check("rst2_count", 32'(fetch_count), 32'd0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      check("idle_valid", 32'(bus.instr_valid), 32'd0);

      // randomized traffic against the reference
      for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 9) == 0),
             8'($urandom),
             ($urandom_range(0, 149) == 0));
      end
      @(negedge clk);
      compare_model();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
